// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the RV32I execute stage to a request/grant/response data memory.
//   Accepts one load or store at a time, checks alignment and funct3 legality,
//   builds a word-aligned request with byte enables and lane-replicated store
//   data, and returns the sign- or zero-extended load lane for write-back.
//
// Ports
//   clk, reset        core clock (rising edge), asynchronous active-high reset
//   lsu_valid/ready   request handshake from the core (ready only while idle)
//   lsu_we            1 = store, 0 = load
//   lsu_funct3        RV32I funct3 selecting access size and signedness
//   lsu_addr/wdata    effective address and rs2 store data
//   lsu_done          one-cycle completion pulse
//   lsu_err           misaligned or illegal funct3, valid with lsu_done
//   lsu_rdata         extended load result; holds until the next load/error
//   mem_req/we/be     memory request, write flag and byte enables
//   mem_addr/wdata    word address and replicated store data
//   mem_gnt           memory accepted the request
//   mem_rvalid/rdata  read response
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  lsu_we,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_done,
    output logic                  lsu_err,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, RESP} state_t;

    state_t     state;
    logic [2:0] funct3_q;
    logic [1:0] off_q;

    // funct3[1:0] encodes the size (byte/half/word); funct3[2] marks the
    // unsigned load variants, which exist only for byte and half.
    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        if (f3[2] && (we || f3[1]))
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the low bytes across all lanes lets the memory pick the
    // lane purely from the byte enables.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] d;
        case (f3[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    // Legal halfwords have off[0]=0, so shifting by the byte offset lines up
    // both byte and halfword lanes at bit 0.
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0]        lane;
        logic signed [7:0]            sb;
        logic signed [15:0]           sh;
        logic signed [DATA_WIDTH-1:0] ext;
        lane = word >> {off, 3'b000};
        sb   = lane[7:0];
        sh   = lane[15:0];
        case (f3)
            3'b000:  ext = DATA_WIDTH'(sb);
            3'b001:  ext = DATA_WIDTH'(sh);
            3'b100:  ext = $signed({24'd0, lane[7:0]});
            3'b101:  ext = $signed({16'd0, lane[15:0]});
            default: ext = $signed(word);
        endcase
        return $unsigned(ext);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lsu_ready <= 1'b1;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
        end else begin
            case (state)
                // IDLE: accept and classify a new request
                IDLE: begin
                    if (lsu_valid) begin
                        lsu_ready <= 1'b0;
                        funct3_q  <= lsu_funct3;
                        off_q     <= lsu_addr[1:0];
                        if (!is_legal(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
                            // Errors complete without touching memory.
                            state     <= RESP;
                            lsu_done  <= 1'b1;
                            lsu_err   <= 1'b1;
                            lsu_rdata <= '0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_we;
                            mem_be    <= byte_enable(lsu_funct3, lsu_addr[1:0]);
                            mem_addr  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= store_data(lsu_funct3, lsu_wdata);
                        end
                    end
                end
                // REQ: hold the request stable until granted
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state    <= RESP;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b0;
                        end else begin
                            state <= WAIT_RV;
                        end
                    end
                end
                // WAIT_RV: capture and extend the read lane
                WAIT_RV: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        lsu_rdata <= load_extend(funct3_q, off_q, mem_rdata);
                        lsu_done  <= 1'b1;
                        lsu_err   <= 1'b0;
                    end
                end
                // RESP: completion pulse lasts exactly this one cycle
                RESP: begin
                    state     <= IDLE;
                    lsu_done  <= 1'b0;
                    lsu_err   <= 1'b0;
                    lsu_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    lsu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'h0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit enc;
        if (we) enc = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    enc = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return enc && ((int'(addr[1:0]) % m_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        longint mask;
        mask = (longint'(1) << m_size(f3)) - 1;
        return 32'(mask << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        logic [31:0] b;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b = (w >> (8 * (i % m_size(f3)))) & 32'hFF;
            r = r | (b << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        longint v;
        int     bits;
        bits = 8 * m_size(f3);
        v = (longint'(word) >> (8 * int'(addr[1:0]))) & ((longint'(1) << bits) - 1);
        if (f3 < 3'd4 && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // One complete transaction; g = gnt stall cycles, r = rvalid delay after gnt.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int g, input int r,
                           input logic [31:0] rword, input bit rv_with_gnt);
        bit          legal;
        logic [31:0] exp_ld;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        legal = m_legal(we, f3, addr);
        @(posedge clk); #1;
        check("ready_idle", 32'(lsu_ready), 32'd1);
        lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        lsu_valid = 1'b0; lsu_we = 1'($urandom); lsu_funct3 = 3'($urandom);
        lsu_addr = $urandom; lsu_wdata = $urandom;
        if (!legal) begin
            @(negedge clk);
            check("err_done", 32'(lsu_done), 32'd1);
            check("err_flag", 32'(lsu_err), 32'd1);
            check("err_rdata", lsu_rdata, 32'h0);
            check("err_noreq", 32'(mem_req), 32'd0);
            model_rdata = 32'h0;
        end else begin
            mem_gnt = (g == 0);
            @(negedge clk);
            check("req", 32'(mem_req), 32'd1);
            check("req_we", 32'(mem_we), 32'(we));
            check("req_be", 32'(mem_be), m_be(f3, addr));
            check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (we) check("req_wdata", mem_wdata, m_wdata(f3, wdata));
            check("req_ready", 32'(lsu_ready), 32'd0);
            check("req_nodone", 32'(lsu_done), 32'd0);
            s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be;
            for (int i = 0; i < g; i++) begin
                @(posedge clk); #1;
                mem_gnt = (i == g - 1);
                @(negedge clk);
                check("stall_req", 32'(mem_req), 32'd1);
                check("stall_addr", mem_addr, s_addr);
                check("stall_be", 32'(mem_be), 32'(s_be));
                check("stall_wdata", mem_wdata, s_wdata);
                check("stall_we", 32'(mem_we), 32'(we));
                check("stall_ready", 32'(lsu_ready), 32'd0);
                check("stall_nodone", 32'(lsu_done), 32'd0);
            end
            if (rv_with_gnt) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = (!we && r == 0);
            mem_rdata = rword;
            if (we) begin
                mem_rvalid = 1'b0;
                @(negedge clk);
                check("st_done", 32'(lsu_done), 32'd1);
                check("st_err", 32'(lsu_err), 32'd0);
                check("st_rdata_hold", lsu_rdata, model_rdata);
                check("st_req_drop", 32'(mem_req), 32'd0);
            end else begin
                @(negedge clk);
                check("ld_req_drop", 32'(mem_req), 32'd0);
                check("ld_nodone", 32'(lsu_done), 32'd0);
                for (int i = 0; i < r; i++) begin
                    @(posedge clk); #1;
                    mem_rvalid = (i == r - 1);
                    @(negedge clk);
                    check("rv_wait_nodone", 32'(lsu_done), 32'd0);
                end
                @(posedge clk); #1;
                mem_rvalid = 1'b0; mem_rdata = $urandom;
                exp_ld = m_load(f3, addr, rword);
                @(negedge clk);
                check("ld_done", 32'(lsu_done), 32'd1);
                check("ld_err", 32'(lsu_err), 32'd0);
                check("ld_rdata", lsu_rdata, exp_ld);
                model_rdata = exp_ld;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("pulse_end", 32'(lsu_done), 32'd0);
        check("back_ready", 32'(lsu_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        #2;
        check("rst_ready", 32'(lsu_ready), 32'd1);
        check("rst_done", 32'(lsu_done), 32'd0);
        check("rst_err", 32'(lsu_err), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", lsu_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        check("lw_const", lsu_rdata, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF7F01, 1'b0);
        check("lb_const", lsu_rdata, 32'hFFFFFF80);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 2, 32'h80FF7F01, 1'b0);
        check("lbu_const", lsu_rdata, 32'h00000080);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80FF7F01, 1'b1);
        check("lh_const", lsu_rdata, 32'hFFFF80FF);
        run_txn(1'b1, 3'b000, 32'h205, 32'h123456AB, 0, 0, 32'h0, 1'b0);
        check("sb_rdata_kept", lsu_rdata, 32'hFFFF80FF);
        run_txn(1'b1, 3'b001, 32'h206, 32'h123456AB, 0, 0, 32'h0, 1'b0);
        run_txn(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5, 0, 32'h0, 1'b1);
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        run_txn(1'b1, 3'b001, 32'h003, 32'h5555, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 3'b110, 32'h000, 32'h0, 0, 0, 32'h0, 1'b0);
        run_txn(1'b1, 3'b100, 32'h000, 32'h0, 0, 0, 32'h0, 1'b0);

        // Reset while waiting for read data
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h100;
        @(posedge clk); #1;
        lsu_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("wrv_noreq", 32'(mem_req), 32'd0);
        check("wrv_nodone", 32'(lsu_done), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(lsu_ready), 32'd1);
        check("mid_rst_done", 32'(lsu_done), 32'd0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        model_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rv_nodone", 32'(lsu_done), 32'd0);
            check("late_rv_ready", 32'(lsu_ready), 32'd1);
            check("late_rv_rdata", lsu_rdata, 32'h0);
        end
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h13579BDF, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                    1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
